// File: rtl/timer_pkg.sv
// Purpose: shared types for the programmable down timer (FSM states, run modes).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_t;

endpackage

// File: rtl/prog_down_timer_if.sv
// Purpose: control/status bundle between a timer user (master) and the timer (slave).
// Latency: n/a (wiring only).
// Backpressure: none; start/stop are single-cycle requests, status is level/pulse.
interface prog_down_timer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, en, mode, load_val,
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, en, mode, load_val,
    output count, tc, busy, done
  );
endinterface

// File: rtl/prog_down_timer.sv
// Purpose: programmable down timer with one-shot/periodic reload and terminal-count pulse.
// Latency: start loads count on the next edge; tc rises one edge after count==0 is seen enabled.
// Backpressure: none; en low freezes RUN, stop aborts, start (re)loads at any time.
module prog_down_timer
  import timer_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  prog_down_timer_if.slave tif
);

  timer_state_t     state_q, state_d;
  timer_mode_t      mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // State and datapath registers; reset aborts any run without emitting tc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // Next state: stop beats start, start beats counting; zero in RUN is expiry, so no wrap.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (tif.stop) begin
      state_d = IDLE;
    end else if (tif.start) begin
      // A restart discards any expiry pending in this same cycle.
      count_d  = tif.load_val;
      reload_d = tif.load_val;
      mode_d   = timer_mode_t'(tif.mode);
      state_d  = RUN;
    end else if (state_q == RUN && tif.en) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
        if (mode_q == PERIODIC) begin
          count_d = reload_q;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  // Every output comes straight from a register.
  assign tif.count = count_q;
  assign tif.tc    = tc_q;
  assign tif.busy  = (state_q == RUN);
  assign tif.done  = (state_q == DONE);

endmodule

// File: tb/tb_prog_down_timer.sv
module tb_prog_down_timer;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  prog_down_timer_if #(.WIDTH(W)) tif ();

  prog_down_timer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif.slave)
  );

  typedef struct {
    int         tgt;
    logic [3:0] c;
    logic       t;
    logic       b;
    logic       d;
    string      name;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int req);
    total = total + 1;
    if (act != req) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endfunction

  // Monitor: each cycle the DUT presents a registered sample; compare against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".when"}, cyc, e.tgt);
        check({e.name, ".count"}, int'(tif.count), int'(e.c));
        check({e.name, ".tc"},    int'(tif.tc),    int'(e.t));
        check({e.name, ".busy"},  int'(tif.busy),  int'(e.b));
        check({e.name, ".done"},  int'(tif.done),  int'(e.d));
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input string name, input logic s, input logic p, input logic e,
                      input logic m, input logic [3:0] lv,
                      input logic [3:0] ec, input logic et, input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    tif.start    = s;
    tif.stop     = p;
    tif.en       = e;
    tif.mode     = m;
    tif.load_val = lv;
    x.tgt  = cyc + 1;
    x.c    = ec;
    x.t    = et;
    x.b    = eb;
    x.d    = ed;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("drain_left", q.size(), 0);
    q.delete();
  endtask

  initial begin
    logic [3:0] pc[12];
    logic       pt[12];
    logic [3:0] gc[12];

    total = 0;
    bad = 0;
    cyc = 0;
    reset = 1'b1;
    tif.start = 1'b0;
    tif.stop = 1'b0;
    tif.en = 1'b0;
    tif.mode = 1'b0;
    tif.load_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    step("rst_idle", 0, 0, 1, 0, 4'd0, 4'd15, 0, 0, 0);

    // One-shot, load 3.
    step("os_ld",  1, 0, 1, 0, 4'd3, 4'd3, 0, 1, 0);
    step("os_2",   0, 0, 1, 0, 4'd0, 4'd2, 0, 1, 0);
    step("os_1",   0, 0, 1, 0, 4'd0, 4'd1, 0, 1, 0);
    step("os_0",   0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0);
    step("os_tc",  0, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);
    step("os_hold",0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);

    // Periodic, load 2: tc every third enabled cycle.
    pc = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    pt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    step("per_ld", 1, 0, 1, 1, 4'd2, 4'd2, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      step($sformatf("per_%0d", i), 0, 0, 1, 0, 4'd0, pc[i], pt[i], 1, 0);

    // Enable gating, periodic load 5, en toggling 0/1.
    gc = '{4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd5};
    step("gate_ld", 1, 0, 1, 1, 4'd5, 4'd5, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      step($sformatf("gate_%0d", i), 0, 0, logic'(i % 2), 0, 4'd0, gc[i], (i == 11), 1, 0);

    // Stop and start together at count 4: stop wins.
    step("ss_ld",   1, 0, 1, 0, 4'd6, 4'd6, 0, 1, 0);
    step("ss_5",    0, 0, 1, 0, 4'd0, 4'd5, 0, 1, 0);
    step("ss_4",    0, 0, 1, 0, 4'd0, 4'd4, 0, 1, 0);
    step("ss_both", 1, 1, 1, 1, 4'd9, 4'd4, 0, 0, 0);
    step("ss_idle", 0, 0, 1, 0, 4'd0, 4'd4, 0, 0, 0);
    step("ss_ld1",  1, 0, 1, 0, 4'd1, 4'd1, 0, 1, 0);
    step("ss_0",    0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0);
    step("ss_tc",   0, 0, 1, 0, 4'd0, 4'd0, 1, 0, 1);

    // Stop from DONE returns to IDLE holding count.
    step("dn_stop", 0, 1, 1, 0, 4'd0, 4'd0, 0, 0, 0);

    // Restart at count 0 with zero periodic load: expiry discarded, then tc every cycle.
    step("rz_ld", 1, 0, 1, 0, 4'd9, 4'd9, 0, 1, 0);
    for (int i = 8; i >= 0; i--)
      step($sformatf("rz_%0d", i), 0, 0, 1, 0, 4'd0, 4'(i), 0, 1, 0);
    step("rz_re", 1, 0, 1, 1, 4'd0, 4'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("rz_tc%0d", i), 0, 0, 1, 0, 4'd0, 4'd0, 1, 1, 0);
    drain();

    // Asynchronous reset mid-run, sampled between edges without a clock.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", int'(tif.count), 15);
    check("arst_tc",    int'(tif.tc),    0);
    check("arst_busy",  int'(tif.busy),  0);
    check("arst_done",  int'(tif.done),  0);
    tif.start = 1'b0;
    tif.stop = 1'b0;
    tif.en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step("arst_idle", 0, 0, 1, 0, 4'd0, 4'd15, 0, 0, 0);
    step("arst_idle2",0, 0, 1, 0, 4'd0, 4'd15, 0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_down_timer.md
Name: prog_down_timer

Overview:
- Parametrised successor to the team's fixed 4-bit free-running down counter.
- Adds programmable width, loadable start value, count enable, one-shot/periodic modes, terminal-count pulse and start/stop control.
- Serves as the general timer/tick generator for peripheral blocks: baud ticks, timeouts, PWM periods.

Parameters:
- WIDTH, 8, counter and load-value width in bits (legal range 2..32).
- RESET_VAL, all-ones of WIDTH, count value forced by reset. Matches the legacy counter's reset-to-max behaviour.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to (re)load and run
- stop  input  1  single-cycle abort request
- en  input  1  count enable; while low, RUN holds count and does not advance
- mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled only on accepted start
- load_val  input  WIDTH  start/reload value; sampled only on accepted start
- count  output  WIDTH  current counter value (registered)
- tc  output  1  terminal-count pulse, exactly one cycle per expiry (registered)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE (one-shot expired)

Behaviour:
- Reset is asynchronous, active-high. Reset values: count = RESET_VAL, reload_q = RESET_VAL, mode_q = 0, tc = 0, busy = 0, done = 0, state = IDLE.
- Reset mid-RUN aborts immediately. No tc is emitted.
- FSM states: IDLE, RUN, DONE. busy = (state == RUN) and done = (state == DONE), both decoded from registered state.
- Priority each cycle: reset > stop > start > counting.
- stop in any state:
  - next state is IDLE; count holds its value; tc = 0.
  - stop and start in the same cycle: stop wins and start is ignored.
- start in IDLE, RUN or DONE:
  - count <= load_val, reload_q <= load_val, mode_q <= mode; next state is RUN.
  - A start during RUN restarts with the new value. A pending expiry in that cycle is discarded and no tc is emitted.
- RUN with en = 1:
  - count != 0: count <= count - 1.
  - count == 0: tc <= 1 next cycle.
    - mode_q = 1: count <= reload_q, stay in RUN.
    - mode_q = 0: count stays 0, next state is DONE.
- RUN with en = 0: everything holds; tc = 0.
- Timing:
  - Expiry period is reload_q + 1 enabled cycles.
  - tc asserts on the first clock edge after the cycle in which count == 0 and en = 1.
  - load_val = 0 with periodic mode gives tc on every enabled cycle.
  - load_val = 0 with one-shot mode gives a single tc, one cycle after start is accepted plus one.
- Arithmetic: count is unsigned WIDTH bits. Decrement never wraps inside RUN, because zero is handled as expiry.
- IDLE and DONE: count holds; en is ignored; tc = 0.
- done stays high until start, stop or reset.
- Outputs are glitch-free registers. There are no combinational input-to-output paths.

Decomposition:
- Shared package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, DONE}
  - typedef enum logic timer_mode_t {ONE_SHOT = 0, PERIODIC = 1}
- The block is a single module with no sub-module. The FSM and datapath are small enough to share one always_ff plus one always_comb next-state block.

Test Plan (WIDTH = 4):
- Reset: assert reset asynchronously between edges -> count = 15, busy = 0, done = 0 and tc = 0 immediately, without waiting for a clock.
- One-shot: start with load_val = 3, mode = 0, en = 1 -> count 3, 2, 1, 0 on cycles 1-4; tc = 1 on cycle 5 only; done = 1 and busy = 0 from cycle 5; count holds 0.
- Periodic: start with load_val = 2, mode = 1, en = 1 for 12 cycles -> tc pulses every 3 cycles (4 pulses); count sequence 2, 1, 0, 2, 1, 0, ...; busy stays 1.
- Enable gating: periodic, load_val = 5, toggle en 1/0 each cycle -> count decrements only on en = 1 cycles; tc every 6 enabled cycles (12 clocks).
- Stop vs start: during RUN at count = 4, assert stop and start together -> state IDLE, count holds 4, no tc. Then start with load_val = 1 -> RUN, count 1, 0, tc.
- Restart and zero load:
  - Start with load_val = 9; at count = 0 assert start with load_val = 0, mode = 1 -> no tc that cycle; count = 0 next cycle; then tc every cycle.
  - Reset mid-run -> count = 15, IDLE.
